// File: rtl/mult16_seq_ctrl_pkg.sv
// Shared definitions for the sequential 16x16 multiplier controller:
// operand/product widths, step count and the controller state encoding.
package mult16_seq_ctrl_pkg;

  localparam int OP_W      = 16;
  localparam int PROD_W    = 32;
  localparam int HALF_W    = 8;
  localparam int NUM_STEPS = 4;
  localparam int STEP_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/array_mult_8x8.sv
// Combinational 8x8 unsigned array multiplier.
// Ports:
//   x, y : 8-bit unsigned operands
//   p    : 16-bit unsigned product x*y
module array_mult_8x8
  import mult16_seq_ctrl_pkg::*;
(
  input  logic [HALF_W-1:0] x,
  input  logic [HALF_W-1:0] y,
  output logic [OP_W-1:0]   p
);

  // Sum of shifted partial products, one row per multiplier bit.
  always_comb begin
    p = '0;
    for (int i = 0; i < HALF_W; i++) begin
      if (y[i]) begin
        p = p + (OP_W'(x) << i);
      end
    end
  end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier. One shared 8x8 array multiplier is
// stepped over the four operand-half combinations and the shifted partial
// products are summed into a 32-bit accumulator.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand pair (in_ready=1)
// MUL   | one partial product accumulated per cycle, steps 0..3
// DONE  | product presented (out_valid=1) until out_ready
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake, a and b captured on accept
//   a, b                : 16-bit unsigned operands
//   out_valid/out_ready : product handshake
//   product             : 32-bit unsigned a*b, held while out_valid
//   busy                : high whenever not in IDLE
module mult16_seq_ctrl
  import mult16_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_t              state, state_nxt;
  logic [OP_W-1:0]     op_a, op_b;
  logic [PROD_W-1:0]   acc;
  logic [STEP_W-1:0]   step;
  logic [HALF_W-1:0]   mx, my;
  logic [OP_W-1:0]     pp;
  logic [PROD_W-1:0]   pp_shifted;
  logic                last_step;

  // step[1] picks the high half of a, step[0] the high half of b.
  always_comb begin
    mx = step[1] ? op_a[OP_W-1:HALF_W] : op_a[HALF_W-1:0];
    my = step[0] ? op_b[OP_W-1:HALF_W] : op_b[HALF_W-1:0];
  end

  array_mult_8x8 u_mult (
    .x (mx),
    .y (my),
    .p (pp)
  );

  always_comb begin
    case (step)
      2'd0:    pp_shifted = PROD_W'(pp);
      2'd1,
      2'd2:    pp_shifted = PROD_W'(pp) << HALF_W;
      default: pp_shifted = PROD_W'(pp) << OP_W;
    endcase
  end

  assign last_step = (step == STEP_W'(NUM_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = MUL;
      MUL:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
      step <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a <= a;
            op_b <= b;
            acc  <= '0;
            step <= '0;
          end
        end
        MUL: begin
          acc  <= acc + pp_shifted;
          step <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = acc;

endmodule
